// File: rtl/menu_pkg.sv
// Shared types for the menu sequencer: page states, menu_sel codes and cursor width.
package menu_pkg;

  localparam int CURSOR_W = 4;

  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    MENU_MODO   = 3'd1,
    MENU_BPM    = 3'd2,
    MENU_TOM    = 3'd3,
    MENU_MUSICA = 3'd4,
    PRONTO      = 3'd5
  } estado_t;

  localparam logic [2:0] SEL_OCIOSO = 3'd0;
  localparam logic [2:0] SEL_MODO   = 3'd1;
  localparam logic [2:0] SEL_BPM    = 3'd2;
  localparam logic [2:0] SEL_TOM    = 3'd3;
  localparam logic [2:0] SEL_MUSICA = 3'd4;
  localparam logic [2:0] SEL_PRONTO = 3'd5;

  function automatic logic [2:0] codigo_menu(input estado_t e);
    logic [2:0] c;
    case (e)
      MENU_MODO:   c = SEL_MODO;
      MENU_BPM:    c = SEL_BPM;
      MENU_TOM:    c = SEL_TOM;
      MENU_MUSICA: c = SEL_MUSICA;
      PRONTO:      c = SEL_PRONTO;
      default:     c = SEL_OCIOSO;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cursor_circular.sv
// Up/down cursor with synchronous clear and a runtime modulus; wraps in both directions.
module cursor_circular
  import menu_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                limpa,
  input  logic                incrementa,
  input  logic                decrementa,
  input  logic [CURSOR_W:0]   modulo,
  output logic [CURSOR_W-1:0] valor
);

  logic [CURSOR_W:0]   modulo_m1;
  logic [CURSOR_W-1:0] ultimo;

  assign modulo_m1 = modulo - 1'b1;
  assign ultimo    = modulo_m1[CURSOR_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor <= '0;
    end else if (limpa) begin
      valor <= '0;
    end else if (incrementa && !decrementa) begin
      valor <= ({1'b0, valor} == modulo_m1) ? '0 : valor + 1'b1;
    end else if (decrementa && !incrementa) begin
      valor <= (valor == '0) ? ultimo : valor - 1'b1;
    end
  end

endmodule

// File: rtl/sequenciador_menu.sv
// Menu sequencer: walks modo/BPM/tom/musica pages and commits one-hot selections.
// Optional inactivity auto-commit is enabled by defining MENU_TIMEOUT_EN.
module sequenciador_menu
  import menu_pkg::*;
#(
  parameter int MODO           = 6,
  parameter int BPM            = 2,
  parameter int TOM            = 4,
  parameter int MUSICA         = 16,
  parameter int GRAVA_IDX      = 3,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inicia_menu,
  input  logic              right_arrow_pressed,
  input  logic              left_arrow_pressed,
  input  logic              enter_pressed,
  output logic [2:0]        menu_sel,
  output logic              mostra_menu,
  output logic [3:0]        cursor,
  output logic [MODO-1:0]   modos,
  output logic [BPM-1:0]    bpm_sel,
  output logic [TOM-1:0]    tom_sel,
  output logic [MUSICA-1:0] musica_sel,
  output logic              menu_pronto
);

  localparam logic [CURSOR_W:0]   MOD_MODO   = (CURSOR_W+1)'(MODO);
  localparam logic [CURSOR_W:0]   MOD_BPM    = (CURSOR_W+1)'(BPM);
  localparam logic [CURSOR_W:0]   MOD_TOM    = (CURSOR_W+1)'(TOM);
  localparam logic [CURSOR_W:0]   MOD_MUSICA = (CURSOR_W+1)'(MUSICA);
  localparam logic [MODO-1:0]     UM_MODO    = 1;
  localparam logic [BPM-1:0]      UM_BPM     = 1;
  localparam logic [TOM-1:0]      UM_TOM     = 1;
  localparam logic [MUSICA-1:0]   UM_MUSICA  = 1;

  estado_t             estado;
  logic [2:0]          tecla_r, tecla_d;
  logic [2:0]          evento;
  logic                ev_right, ev_left, ev_enter;
  logic                em_pagina, expirou, confirma, passo_dir, passo_esq, limpa_cursor;
  logic [CURSOR_W:0]   modulo;
  logic [CURSOR_W-1:0] cur;

  // Keys registered once; the delayed copy turns levels into single press events.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tecla_r <= '0;
      tecla_d <= '0;
    end else begin
      tecla_r <= {enter_pressed, left_arrow_pressed, right_arrow_pressed};
      tecla_d <= tecla_r;
    end
  end

  assign evento   = tecla_r & ~tecla_d;
  assign ev_right = evento[0];
  assign ev_left  = evento[1];
  assign ev_enter = evento[2];

  assign em_pagina    = (estado == MENU_MODO) || (estado == MENU_BPM) ||
                        (estado == MENU_TOM)  || (estado == MENU_MUSICA);
  assign confirma     = em_pagina && !inicia_menu && (ev_enter || expirou);
  assign passo_dir    = em_pagina && !inicia_menu && !confirma && ev_right && !ev_left;
  assign passo_esq    = em_pagina && !inicia_menu && !confirma && ev_left && !ev_right;
  assign limpa_cursor = inicia_menu || confirma;

`ifdef MENU_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] CARGA = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] ociosidade;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ociosidade <= CARGA;
    end else if (!em_pagina || limpa_cursor || (|evento)) begin
      ociosidade <= CARGA;
    end else if (ociosidade != '0) begin
      ociosidade <= ociosidade - 1'b1;
    end
  end

  assign expirou = em_pagina && (ociosidade == '0);
`else
  assign expirou = 1'b0;
`endif

  always_comb begin
    modulo = (CURSOR_W+1)'(1);
    case (estado)
      MENU_MODO:   modulo = MOD_MODO;
      MENU_BPM:    modulo = MOD_BPM;
      MENU_TOM:    modulo = MOD_TOM;
      MENU_MUSICA: modulo = MOD_MUSICA;
      default:     modulo = (CURSOR_W+1)'(1);
    endcase
  end

  cursor_circular u_cursor (
    .clock      (clock),
    .reset      (reset),
    .limpa      (limpa_cursor),
    .incrementa (passo_dir),
    .decrementa (passo_esq),
    .modulo     (modulo),
    .valor      (cur)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado     <= OCIOSO;
      modos      <= UM_MODO;
      bpm_sel    <= UM_BPM;
      tom_sel    <= UM_TOM;
      musica_sel <= UM_MUSICA;
    end else if (inicia_menu) begin
      estado <= MENU_MODO;
    end else if (confirma) begin
      case (estado)
        MENU_MODO: begin
          modos  <= UM_MODO << cur;
          estado <= MENU_BPM;
        end
        MENU_BPM: begin
          bpm_sel <= UM_BPM << cur;
          estado  <= MENU_TOM;
        end
        MENU_TOM: begin
          tom_sel <= UM_TOM << cur;
          // Record mode has no song to pick.
          estado  <= modos[GRAVA_IDX] ? PRONTO : MENU_MUSICA;
        end
        MENU_MUSICA: begin
          musica_sel <= UM_MUSICA << cur;
          estado     <= PRONTO;
        end
        default: estado <= OCIOSO;
      endcase
    end else if (estado == PRONTO) begin
      estado <= OCIOSO;
    end
  end

  assign menu_sel    = codigo_menu(estado);
  assign mostra_menu = em_pagina;
  assign menu_pronto = (estado == PRONTO);
  assign cursor      = cur;

endmodule

// File: tb/tb_sequenciador_menu.sv
// Bench for sequenciador_menu: page-level reference model, directed scenarios, random keys.
module tb_sequenciador_menu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inicia_menu = 1'b0;
  logic        right_arrow_pressed = 1'b0;
  logic        left_arrow_pressed = 1'b0;
  logic        enter_pressed = 1'b0;
  logic [2:0]  menu_sel;
  logic        mostra_menu;
  logic [3:0]  cursor;
  logic [5:0]  modos;
  logic [1:0]  bpm_sel;
  logic [3:0]  tom_sel;
  logic [15:0] musica_sel;
  logic        menu_pronto;

  int vectors = 0;
  int miscompares = 0;

  sequenciador_menu dut (
    .clock               (clock),
    .reset               (reset),
    .inicia_menu         (inicia_menu),
    .right_arrow_pressed (right_arrow_pressed),
    .left_arrow_pressed  (left_arrow_pressed),
    .enter_pressed       (enter_pressed),
    .menu_sel            (menu_sel),
    .mostra_menu         (mostra_menu),
    .cursor              (cursor),
    .modos               (modos),
    .bpm_sel             (bpm_sel),
    .tom_sel             (tom_sel),
    .musica_sel          (musica_sel),
    .menu_pronto         (menu_pronto)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string nome, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: dut=0x%0h expected=0x%0h at %0t", nome, act, exp, $time);
    end
  endtask

  // Reference model: page number, cursor, and committed index per page.
  int m_pag = 0;
  int m_cur = 0;
  int m_sel[1:4] = '{0, 0, 0, 0};
  bit m_ant[3] = '{0, 0, 0};   // key levels seen one edge ago
  bit m_ant2[3] = '{0, 0, 0};  // key levels seen two edges ago

  function automatic int opcoes(input int p);
    case (p)
      1: return 6;
      2: return 2;
      3: return 4;
      default: return 16;
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pag = 0;
      m_cur = 0;
      for (int i = 1; i <= 4; i++) m_sel[i] = 0;
      for (int i = 0; i < 3; i++) begin
        m_ant[i] = 0;
        m_ant2[i] = 0;
      end
    end else begin
      bit pr, pl, pe;
      int n;
      pr = m_ant[0] && !m_ant2[0];
      pl = m_ant[1] && !m_ant2[1];
      pe = m_ant[2] && !m_ant2[2];
      for (int i = 0; i < 3; i++) m_ant2[i] = m_ant[i];
      m_ant[0] = right_arrow_pressed;
      m_ant[1] = left_arrow_pressed;
      m_ant[2] = enter_pressed;
      n = opcoes(m_pag);
      if (inicia_menu) begin
        m_pag = 1;
        m_cur = 0;
      end else if (m_pag == 5) begin
        m_pag = 0;
      end else if (m_pag >= 1 && m_pag <= 4) begin
        if (pe) begin
          m_sel[m_pag] = m_cur;
          if (m_pag == 3 && m_sel[1] == 3) m_pag = 5;
          else m_pag = m_pag + 1;
          m_cur = 0;
        end else if (pr && !pl) begin
          m_cur = (m_cur + 1) % n;
        end else if (pl && !pr) begin
          m_cur = (m_cur + n - 1) % n;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      cmp("menu_sel", 32'(menu_sel), 32'(m_pag));
      cmp("mostra_menu", 32'(mostra_menu), 32'(m_pag >= 1 && m_pag <= 4));
      cmp("menu_pronto", 32'(menu_pronto), 32'(m_pag == 5));
      cmp("cursor", 32'(cursor), 32'(m_cur));
      cmp("modos", 32'(modos), 32'(1) << m_sel[1]);
      cmp("bpm_sel", 32'(bpm_sel), 32'(1) << m_sel[2]);
      cmp("tom_sel", 32'(tom_sel), 32'(1) << m_sel[3]);
      cmp("musica_sel", 32'(musica_sel), 32'(1) << m_sel[4]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_tecla(input int k, input logic v);
    case (k)
      0: right_arrow_pressed = v;
      1: left_arrow_pressed = v;
      default: enter_pressed = v;
    endcase
  endtask

  // Press and release; the press has been acted on when this returns.
  task automatic tecla(input int k, input int hold);
    set_tecla(k, 1'b1);
    tick(hold);
    set_tecla(k, 1'b0);
    tick(1);
  endtask

  task automatic inicia();
    inicia_menu = 1'b1;
    tick(1);
    inicia_menu = 1'b0;
  endtask

  initial begin
    tick(2);
    cmp("lit_rst_menu_sel", 32'(menu_sel), 32'd0);
    cmp("lit_rst_modos", 32'(modos), 32'h01);
    cmp("lit_rst_pronto", 32'(menu_pronto), 32'd0);
    reset = 1'b0;
    tick(1);

    // modo page: right x2 then enter, with two-cycle commit latency
    inicia();
    cmp("lit_modo_page", 32'(menu_sel), 32'd1);
    tecla(0, 1);
    tecla(0, 1);
    enter_pressed = 1'b1;
    tick(1);
    cmp("lit_commit_latency", 32'(modos), 32'h01);
    tick(1);
    cmp("lit_modos_idx2", 32'(modos), 32'h04);
    cmp("lit_bpm_page", 32'(menu_sel), 32'd2);
    cmp("lit_cursor_clear", 32'(cursor), 32'd0);
    enter_pressed = 1'b0;
    tick(1);

    // enter and right rising together: commit wins, cursor unchanged
    enter_pressed = 1'b1;
    right_arrow_pressed = 1'b1;
    tick(2);
    cmp("lit_bpm_enter_prio", 32'(bpm_sel), 32'h1);
    cmp("lit_tom_page", 32'(menu_sel), 32'd3);
    enter_pressed = 1'b0;
    right_arrow_pressed = 1'b0;
    tick(1);

    tecla(1, 1);
    cmp("lit_tom_left_wrap", 32'(cursor), 32'd3);
    tecla(2, 1);
    cmp("lit_tom_sel", 32'(tom_sel), 32'h8);
    cmp("lit_musica_page", 32'(menu_sel), 32'd4);
    repeat (16) tecla(0, 1);
    cmp("lit_musica_right_wrap", 32'(cursor), 32'd0);
    enter_pressed = 1'b1;
    tick(2);
    cmp("lit_musica_sel", 32'(musica_sel), 32'h0001);
    cmp("lit_pronto_sel", 32'(menu_sel), 32'd5);
    cmp("lit_pronto_pulse", 32'(menu_pronto), 32'd1);
    enter_pressed = 1'b0;
    tick(1);
    cmp("lit_pronto_one_cycle", 32'(menu_pronto), 32'd0);
    cmp("lit_back_idle", 32'(menu_sel), 32'd0);

    // asynchronous reset in the middle of the BPM page
    inicia();
    tecla(0, 1);
    tecla(2, 1);
    tecla(0, 1);
    cmp("lit_pre_reset_sel", 32'(menu_sel), 32'd2);
    cmp("lit_pre_reset_modos", 32'(modos), 32'h02);
    #3 reset = 1'b1;
    #1;
    cmp("lit_async_menu_sel", 32'(menu_sel), 32'd0);
    cmp("lit_async_modos", 32'(modos), 32'h01);
    cmp("lit_async_bpm", 32'(bpm_sel), 32'h1);
    cmp("lit_async_tom", 32'(tom_sel), 32'h1);
    cmp("lit_async_musica", 32'(musica_sel), 32'h0001);
    cmp("lit_async_cursor", 32'(cursor), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(1);

    // full pass choosing song 5
    inicia();
    tecla(0, 1);
    tecla(2, 1);
    tecla(2, 1);
    tecla(2, 1);
    repeat (5) tecla(0, 1);
    tecla(2, 1);
    cmp("lit_song5", 32'(musica_sel), 32'h0020);
    tick(1);

    // record mode skips the song page and keeps the old song
    inicia();
    repeat (3) tecla(0, 1);
    tecla(2, 1);
    cmp("lit_modos_grava", 32'(modos), 32'h08);
    tecla(2, 1);
    enter_pressed = 1'b1;
    tick(2);
    cmp("lit_grava_pronto", 32'(menu_sel), 32'd5);
    cmp("lit_grava_song_kept", 32'(musica_sel), 32'h0020);
    enter_pressed = 1'b0;
    tick(1);

    // simultaneous arrows ignored; held key steps once
    inicia();
    tecla(0, 1);
    right_arrow_pressed = 1'b1;
    left_arrow_pressed = 1'b1;
    tick(1);
    right_arrow_pressed = 1'b0;
    left_arrow_pressed = 1'b0;
    tick(2);
    cmp("lit_both_arrows", 32'(cursor), 32'd1);
    right_arrow_pressed = 1'b1;
    tick(100);
    cmp("lit_held_key", 32'(cursor), 32'd2);
    right_arrow_pressed = 1'b0;
    tick(2);
    cmp("lit_held_release", 32'(cursor), 32'd2);

    // page waits for enter
    tick(1000);
    cmp("lit_no_timeout", 32'(menu_sel), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      right_arrow_pressed = ($urandom_range(0, 3) == 0);
      left_arrow_pressed  = ($urandom_range(0, 3) == 0);
      enter_pressed       = ($urandom_range(0, 5) == 0);
      inicia_menu         = ($urandom_range(0, 79) == 0);
      tick(1);
    end
    right_arrow_pressed = 1'b0;
    left_arrow_pressed = 1'b0;
    enter_pressed = 1'b0;
    inicia_menu = 1'b0;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sequenciador_menu.md
Name: sequenciador_menu

Overview:
Menu sequencer that configures the game datapath before a round starts. It walks the player through four pages (modo, BPM, tom, música) using arrow and enter keys, and keeps a wrapping cursor per page. Each selection is committed into a one-hot configuration register that the datapath reads. It drives the menu_sel / mostra_menu indication and emits a single-cycle menu_pronto to the main control unit when configuration is complete.

Parameters:
MODO, 6, number of game modes (one-hot width of modos)
BPM, 2, number of tempo options
TOM, 4, number of key/tone options
MUSICA, 16, number of songs
GRAVA_IDX, 3, modo index of "record" mode; selecting it skips the música page
TIMEOUT_CYCLES, 5000, inactivity limit in clock cycles (used only with the optional feature)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
inicia_menu  in  1  start or restart menu sequence (level; sampled per cycle)
right_arrow_pressed  in  1  key level, debounced upstream
left_arrow_pressed  in  1  key level, debounced upstream
enter_pressed  in  1  key level, debounced upstream
menu_sel  out  3  current page: 0 idle, 1 modo, 2 bpm, 3 tom, 4 musica, 5 pronto
mostra_menu  out  1  high in pages 1-4
cursor  out  4  current cursor index (zero-extended)
modos  out  MODO  committed mode, one-hot
bpm_sel  out  BPM  committed BPM, one-hot
tom_sel  out  TOM  committed tone, one-hot
musica_sel  out  MUSICA  committed song, one-hot
menu_pronto  out  1  one-cycle pulse on entry to PRONTO

Behaviour:
- Reset (async): state OCIOSO, cursor=0, every one-hot register = bit0 set (e.g. modos=6'b000001), menu_sel=0, mostra_menu=0, menu_pronto=0.
- Key inputs are registered once. Internal rising-edge detect produces one event per press; a held key produces no repeat.
- Event priority per cycle: inicia_menu > enter > arrows. Left and right rising in the same cycle: both ignored.
- States: OCIOSO -> (inicia_menu) MENU_MODO -> MENU_BPM -> MENU_TOM -> MENU_MUSICA -> PRONTO -> OCIOSO on the following cycle.
  - Page advance occurs on an enter event only.
  - In MENU_TOM, if the committed modo index == GRAVA_IDX, enter goes directly to PRONTO.
- Cursor is cleared to 0 on every page entry.
  - Right: cursor+1, wraps from N-1 to 0, where N is the option count of the page.
  - Left: cursor-1, wraps from 0 to N-1.
- Enter commits: register of the current page <= one-hot(cursor), written in the same edge as the state change. Outputs reflect the new value in the next cycle.
- Commit latency: 2 cycles from the key level rising to the one-hot register update (1 input register + 1 edge/FSM).
- menu_pronto is high exactly one cycle, during the PRONTO state.
- inicia_menu asserted in any state (including mid-page) -> MENU_MODO next cycle, cursor=0. Already committed registers retain their values until recommitted.
- Arrow events in OCIOSO/PRONTO are ignored. Enter in OCIOSO is ignored.
- menu_sel and mostra_menu are decoded combinationally from the state register (glitch-free, registered state).

Optional Feature:
MENU_TIMEOUT_EN
- Defined: an inactivity counter clears on any key event or page entry and counts while in pages 1-4. At TIMEOUT_CYCLES-1 it forces a commit of the current cursor exactly as an enter event would.
- Undefined: no counter exists, and pages wait indefinitely for enter.

Decomposition:
- Shared package menu_pkg:
  - state enum (OCIOSO, MENU_MODO, MENU_BPM, MENU_TOM, MENU_MUSICA, PRONTO)
  - menu_sel codes 0-5
  - cursor width constant (4)
- Sub-module cursor_circular: up/down counter with synchronous clear, runtime modulus input, and wrap in both directions. It is instantiated once; the modulus is muxed from the page.

Test Plan:
- Reset mid-MENU_BPM -> immediately menu_sel=0, modos=000001, bpm_sel=01, tom_sel=0001, musica_sel=0x0001.
- inicia_menu, then right x2 + enter -> modos=000100, menu_sel=2 two cycles later, cursor=0.
- In MENU_TOM: left x1 -> cursor=3 (wrap). In MENU_MUSICA: right x16 -> cursor=0 (wrap). Enter -> musica_sel=0x0001, then PRONTO with a one-cycle menu_pronto.
- Select modo 3 (GRAVA_IDX), enter through BPM and TOM -> PRONTO reached with no MENU_MUSICA visit; musica_sel unchanged.
- Enter and right rising in the same cycle in MENU_BPM -> commit with cursor unchanged (bpm_sel=01). Left+right together -> no cursor change. A key held 100 cycles -> a single step.
- With MENU_TIMEOUT_EN and TIMEOUT_CYCLES=50: no keys in MENU_MODO after right x1 -> after 50 cycles modos=000010 and menu_sel=2. Without the macro -> still menu_sel=1 after 1000 cycles.
